// File: rtl/wb_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// wb_mem_ctrl_pkg
// Shared widths, encodings and small helpers for the memory-access /
// writeback controller.
//   - wb_Sel encodings (which result goes to the register file)
//   - mem_val encodings (access size)
//   - controller state encodings
//   - helpers for alignment check and store lane generation
// ---------------------------------------------------------------------------
package wb_mem_ctrl_pkg;

  localparam int BITS32 = 32;
  localparam int BITS5  = 5;
  localparam int BITS2  = 2;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_RSV = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_W    = 2'b01,
    MEM_H    = 2'b10,
    MEM_B    = 2'b11
  } mem_val_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  // Byte accesses are always aligned; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic r;
    r = 1'b0;
    case (size)
      MEM_W:   r = (off != 2'b00);
      MEM_H:   r = off[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size,
                                            input logic [1:0] off);
    logic [3:0] r;
    r = 4'b0000;
    case (size)
      MEM_W:   r = 4'b1111;
      MEM_H:   r = 4'b0011 << off;
      MEM_B:   r = 4'b0001 << off;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Data is replicated across lanes so the strobes alone pick the bytes.
  function automatic logic [31:0] store_data(input logic [1:0]  size,
                                             input logic [31:0] data);
    logic [31:0] r;
    r = data;
    case (size)
      MEM_H:   r = {2{data[15:0]}};
      MEM_B:   r = {4{data[7:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_mem_ctrl_load_align.sv
// ---------------------------------------------------------------------------
// wb_mem_ctrl_load_align
// Combinational load lane select plus sign/zero extension.
// Ports:
//   i_resp_data [31:0]  raw word returned by data memory
//   i_off       [1:0]   byte offset of the access (addr[1:0])
//   i_size      [1:0]   access size (mem_val encoding)
//   i_unsigned          1 = zero-extend, 0 = sign-extend
//   o_data      [31:0]  value to write into the register file
// ---------------------------------------------------------------------------
module wb_mem_ctrl_load_align
  import wb_mem_ctrl_pkg::*;
(
  input  logic [BITS32-1:0] i_resp_data,
  input  logic [1:0]        i_off,
  input  logic [BITS2-1:0]  i_size,
  input  logic              i_unsigned,
  output logic [BITS32-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0:    w_byte = i_resp_data[7:0];
      2'd1:    w_byte = i_resp_data[15:8];
      2'd2:    w_byte = i_resp_data[23:16];
      default: w_byte = i_resp_data[31:24];
    endcase
  end

  // Halves are aligned, so only addr[1] picks the lane.
  assign w_half = i_off[1] ? i_resp_data[31:16] : i_resp_data[15:0];

  always_comb begin
    o_data = i_resp_data;
    case (i_size)
      MEM_B:   o_data = {{24{w_byte[7]  & ~i_unsigned}}, w_byte};
      MEM_H:   o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_data = i_resp_data;
    endcase
  end

endmodule

// File: rtl/wb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// wb_mem_ctrl
// Memory-access and writeback stage controller. Accepts one bundle per cycle
// from the EX/MEM register, performs loads/stores over a valid/ready port,
// writes the selected result to the register file and publishes that write
// as a forwarding source.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a bundle; non-memory bundles retire from here
// ST_REQ  | dmem request held valid with stable fields until ready
// ST_WAIT | load issued; waiting for dmem_resp_valid
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid, alu_out2, wdata, wb_addr,
//   rf_wen2, mem_rw2, mem_val2, pc2,
//   instruction2, wb_Sel2              incoming instruction bundle
//   stall                              upstream must hold its bundle
//   dmem_req_valid/ready, dmem_we,
//   dmem_addr, dmem_wdata, dmem_wstrb  data memory request port
//   dmem_resp_valid, dmem_resp_data    load response
//   rf_we, rf_waddr, rf_wdata          register file write port
//   fwd_valid, fwd_addr, fwd_data      forwarding copy of the rf write
//   misalign                           one-cycle misaligned access pulse
// ---------------------------------------------------------------------------
module wb_mem_ctrl
  import wb_mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BITS32-1:0] alu_out2,
  input  logic [BITS32-1:0] wdata,
  input  logic [BITS5-1:0]  wb_addr,
  input  logic              rf_wen2,
  input  logic              mem_rw2,
  input  logic [BITS2-1:0]  mem_val2,
  input  logic [BITS32-1:0] pc2,
  input  logic [BITS32-1:0] instruction2,
  input  logic [BITS2-1:0]  wb_Sel2,
  output logic              stall,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [BITS32-1:0] dmem_addr,
  output logic [BITS32-1:0] dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_resp_valid,
  input  logic [BITS32-1:0] dmem_resp_data,
  output logic              rf_we,
  output logic [BITS5-1:0]  rf_waddr,
  output logic [BITS32-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [BITS5-1:0]  fwd_addr,
  output logic [BITS32-1:0] fwd_data,
  output logic              misalign
);

  state_e             r_state;
  logic [1:0]         r_off;
  logic [BITS2-1:0]   r_size;
  logic               r_unsigned;
  logic [BITS5-1:0]   r_rd;
  logic               r_wen;

  logic               w_is_mem;
  logic               w_misaligned;
  logic [BITS32-1:0]  w_wb_data;
  logic [BITS32-1:0]  w_load_data;
  logic               w_unused;

  assign w_is_mem     = (mem_val2 != MEM_NONE);
  assign w_misaligned = is_misaligned(mem_val2, alu_out2[1:0]);

  // Only bit 14 (funct3 unsigned flag) of the instruction matters here.
  assign w_unused = ^{instruction2[31:15], instruction2[13:0]};

  // Load data cannot be available for a non-memory bundle, so WB_MEM and
  // the reserved code fall back to the ALU result.
  always_comb begin
    w_wb_data = alu_out2;
    if (wb_Sel2 == WB_PC4) w_wb_data = pc2 + 32'd4;
  end

  assign stall = (r_state != ST_IDLE) || (in_valid && w_is_mem && !w_misaligned);

  wb_mem_ctrl_load_align u_load_align (
    .i_resp_data (dmem_resp_data),
    .i_off       (r_off),
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .o_data      (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_off          <= 2'b00;
      r_size         <= MEM_NONE;
      r_unsigned     <= 1'b0;
      r_rd           <= '0;
      r_wen          <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wstrb     <= 4'b0000;
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      misalign       <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      misalign <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!w_is_mem) begin
              rf_we    <= rf_wen2 && (wb_addr != '0);
              rf_waddr <= wb_addr;
              rf_wdata <= w_wb_data;
            end else if (w_misaligned) begin
              misalign <= 1'b1;
            end else begin
              r_state        <= ST_REQ;
              r_off          <= alu_out2[1:0];
              r_size         <= mem_val2;
              r_unsigned     <= instruction2[14];
              r_rd           <= wb_addr;
              r_wen          <= rf_wen2;
              dmem_req_valid <= 1'b1;
              dmem_we        <= mem_rw2;
              dmem_addr      <= {alu_out2[31:2], 2'b00};
              dmem_wdata     <= store_data(mem_val2, wdata);
              dmem_wstrb     <= mem_rw2 ? store_strb(mem_val2, alu_out2[1:0]) : 4'b0000;
            end
          end
        end
        ST_REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            r_state        <= dmem_we ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dmem_resp_valid) begin
            rf_we    <= r_wen && (r_rd != '0);
            rf_waddr <= r_rd;
            rf_wdata <= w_load_data;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;

endmodule

// File: tb/tb_wb_mem_ctrl.sv
module tb_wb_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] alu_out2;
  logic [31:0] wdata;
  logic [4:0]  wb_addr;
  logic        rf_wen2;
  logic        mem_rw2;
  logic [1:0]  mem_val2;
  logic [31:0] pc2;
  logic [31:0] instruction2;
  logic [1:0]  wb_Sel2;
  logic        stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        misalign;

  int n_pass;
  int n_total;

  wb_mem_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .alu_out2        (alu_out2),
    .wdata           (wdata),
    .wb_addr         (wb_addr),
    .rf_wen2         (rf_wen2),
    .mem_rw2         (mem_rw2),
    .mem_val2        (mem_val2),
    .pc2             (pc2),
    .instruction2    (instruction2),
    .wb_Sel2         (wb_Sel2),
    .stall           (stall),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_wstrb      (dmem_wstrb),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_data  (dmem_resp_data),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .fwd_valid       (fwd_valid),
    .fwd_addr        (fwd_addr),
    .fwd_data        (fwd_data),
    .misalign        (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid        = 1'b0;
    alu_out2        = 32'h0;
    wdata           = 32'h0;
    wb_addr         = 5'd0;
    rf_wen2         = 1'b0;
    mem_rw2         = 1'b0;
    mem_val2        = 2'b00;
    pc2             = 32'h0;
    instruction2    = 32'h0;
    wb_Sel2         = 2'b00;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = 32'h0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst_stall",     stall,          0);
    chk("rst_req_valid", dmem_req_valid, 0);
    chk("rst_we",        dmem_we,        0);
    chk("rst_addr",      dmem_addr,      0);
    chk("rst_wdata",     dmem_wdata,     0);
    chk("rst_wstrb",     dmem_wstrb,     0);
    chk("rst_rf_we",     rf_we,          0);
    chk("rst_rf_waddr",  rf_waddr,       0);
    chk("rst_rf_wdata",  rf_wdata,       0);
    chk("rst_fwd_valid", fwd_valid,      0);
    chk("rst_misalign",  misalign,       0);
    #10 rst_n = 1'b1;
    tick();

    // ALU op, then back-to-back
    in_valid = 1'b1; alu_out2 = 32'h1234; wb_Sel2 = 2'b00; wb_addr = 5'd5; rf_wen2 = 1'b1;
    #1 chk("alu_stall", stall, 0);
    tick();
    chk("alu_rf_we",    rf_we,     1);
    chk("alu_waddr",    rf_waddr,  5);
    chk("alu_wdata",    rf_wdata,  32'h1234);
    chk("alu_fwd",      fwd_valid, 1);
    chk("alu_fwd_data", fwd_data,  32'h1234);
    alu_out2 = 32'h55; wb_addr = 5'd6;
    tick();
    chk("b2b_rf_we", rf_we,    1);
    chk("b2b_waddr", rf_waddr, 6);
    chk("b2b_wdata", rf_wdata, 32'h55);

    // JAL-style link value, then rd=0
    pc2 = 32'h100; wb_Sel2 = 2'b10; wb_addr = 5'd1;
    tick();
    chk("jal_rf_we", rf_we,    1);
    chk("jal_waddr", rf_waddr, 1);
    chk("jal_wdata", rf_wdata, 32'h104);
    wb_addr = 5'd0;
    tick();
    chk("x0_rf_we", rf_we,     0);
    chk("x0_fwd",   fwd_valid, 0);
    idle_inputs();
    tick();
    chk("pulse_rf_we", rf_we, 0);

    // Signed byte load at 0x2003, ready delayed two cycles
    in_valid = 1'b1; alu_out2 = 32'h2003; mem_val2 = 2'b11; mem_rw2 = 1'b0;
    instruction2 = 32'h0; wb_addr = 5'd7; rf_wen2 = 1'b1; wb_Sel2 = 2'b01;
    #1 chk("lb_accept_stall", stall, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("lb_req_valid", dmem_req_valid, 1);
    chk("lb_addr",      dmem_addr,      32'h2000);
    chk("lb_we",        dmem_we,        0);
    chk("lb_stall_req", stall,          1);
    tick();
    chk("lb_hold1", dmem_req_valid, 1);
    tick();
    chk("lb_hold2", dmem_req_valid, 1);
    chk("lb_addr2", dmem_addr,      32'h2000);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    #1;
    chk("lb_req_drop",   dmem_req_valid, 0);
    chk("lb_stall_wait", stall,          1);
    chk("lb_no_we_yet",  rf_we,          0);
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h80FFFFFF;
    tick();
    dmem_resp_valid = 1'b0;
    #1;
    chk("lb_rf_we",    rf_we,    1);
    chk("lb_waddr",    rf_waddr, 7);
    chk("lb_wdata",    rf_wdata, 32'hFFFFFF80);
    chk("lb_stall_lo", stall,    0);
    tick();
    chk("lb_pulse", rf_we, 0);

    // LHU at 0x2002, ready immediately
    in_valid = 1'b1; alu_out2 = 32'h2002; mem_val2 = 2'b10; mem_rw2 = 1'b0;
    instruction2 = 32'h0000_4000; wb_addr = 5'd8; rf_wen2 = 1'b1; wb_Sel2 = 2'b01;
    dmem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'hBEEF0000;
    tick();
    dmem_resp_valid = 1'b0;
    #1;
    chk("lhu_rf_we", rf_we,    1);
    chk("lhu_waddr", rf_waddr, 8);
    chk("lhu_wdata", rf_wdata, 32'h0000BEEF);
    idle_inputs();
    tick();

    // Store half at 0x10
    in_valid = 1'b1; alu_out2 = 32'h10; wdata = 32'hABCD; mem_val2 = 2'b10; mem_rw2 = 1'b1;
    wb_addr = 5'd9; rf_wen2 = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    chk("sh_req_valid", dmem_req_valid, 1);
    chk("sh_we",        dmem_we,        1);
    chk("sh_addr",      dmem_addr,      32'h10);
    chk("sh_wstrb",     dmem_wstrb,     4'b0011);
    chk("sh_wdata",     dmem_wdata,     32'hABCDABCD);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    #1;
    chk("sh_done_valid", dmem_req_valid, 0);
    chk("sh_done_stall", stall,          0);
    chk("sh_no_rf_we",   rf_we,          0);

    // Store byte at 0x13
    in_valid = 1'b1; alu_out2 = 32'h13; wdata = 32'h5A; mem_val2 = 2'b11; mem_rw2 = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("sb_wstrb", dmem_wstrb, 4'b1000);
    chk("sb_wdata", dmem_wdata, 32'h5A5A5A5A);
    chk("sb_addr",  dmem_addr,  32'h10);
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    idle_inputs();
    tick();

    // Misaligned word at 0x6
    in_valid = 1'b1; alu_out2 = 32'h6; mem_val2 = 2'b01; mem_rw2 = 1'b0;
    wb_addr = 5'd3; rf_wen2 = 1'b1; wb_Sel2 = 2'b01;
    #1 chk("mis_stall", stall, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("mis_pulse",     misalign,       1);
    chk("mis_no_req",    dmem_req_valid, 0);
    chk("mis_no_rf_we",  rf_we,          0);
    tick();
    chk("mis_pulse_end", misalign,       0);
    idle_inputs();

    // Reset while waiting for a load response
    in_valid = 1'b1; alu_out2 = 32'h40; mem_val2 = 2'b01; mem_rw2 = 1'b0;
    wb_addr = 5'd10; rf_wen2 = 1'b1; wb_Sel2 = 2'b01;
    dmem_req_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    dmem_req_ready = 1'b0;
    #1 chk("rw_stall_wait", stall, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_req_valid", dmem_req_valid, 0);
    chk("rw_stall",     stall,          0);
    #1 rst_n = 1'b1;
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h1234;
    tick();
    dmem_resp_valid = 1'b0;
    tick();
    chk("rw_late_resp", rf_we, 0);
    chk("rw_late_fwd",  fwd_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
